// File: rtl/qpu_ifu_flush_ctrl_if.sv
// ----------------------------------------------------------------------------
// qpu_ifu_flush_ctrl_if
//   Groups the signals between the branch-resolve stage, the flush controller
//   and the IFU fetch stage.
//   master : the surrounding pipeline (flush source, fetch stage)
//   slave  : the flush controller
//   Signals:
//     brchmis_flush_req/ack      mispredict flush handshake
//     brchmis_flush_add_op1/op2  redirect adder operands
//     ifu_redirect_valid/ready   PC redirect handshake, ifu_redirect_pc target
//     ifu_req_hsk / ifu_rsp_hsk  fetch request / response handshake pulses
//     ifu_req_block              fetch stage must not issue a request
//     ifu_rsp_kill               current response is wrong-path, drop it
//     ost_err                    sticky outstanding-tracking protocol error
// ----------------------------------------------------------------------------
interface qpu_ifu_flush_ctrl_if #(
  parameter int PC_SIZE = 32
);
  logic               brchmis_flush_req;
  logic               brchmis_flush_ack;
  logic [PC_SIZE-1:0] brchmis_flush_add_op1;
  logic [PC_SIZE-1:0] brchmis_flush_add_op2;
  logic               ifu_redirect_valid;
  logic               ifu_redirect_ready;
  logic [PC_SIZE-1:0] ifu_redirect_pc;
  logic               ifu_req_hsk;
  logic               ifu_rsp_hsk;
  logic               ifu_req_block;
  logic               ifu_rsp_kill;
  logic               ost_err;

  modport master (
    output brchmis_flush_req, brchmis_flush_add_op1, brchmis_flush_add_op2,
           ifu_redirect_ready, ifu_req_hsk, ifu_rsp_hsk,
    input  brchmis_flush_ack, ifu_redirect_valid, ifu_redirect_pc,
           ifu_req_block, ifu_rsp_kill, ost_err
  );

  modport slave (
    input  brchmis_flush_req, brchmis_flush_add_op1, brchmis_flush_add_op2,
           ifu_redirect_ready, ifu_req_hsk, ifu_rsp_hsk,
    output brchmis_flush_ack, ifu_redirect_valid, ifu_redirect_pc,
           ifu_req_block, ifu_rsp_kill, ost_err
  );
endinterface

// File: rtl/qpu_ifu_flush_ctrl.sv
// ----------------------------------------------------------------------------
// qpu_ifu_flush_ctrl
//   Accepts a branch-mispredict flush, computes the redirect target, drives a
//   PC redirect into the fetch stage and kills the wrong-path fetch responses
//   that were already in flight when the flush was accepted.
//   Ports:
//     clk  clock
//     rst  synchronous active-high reset
//     bus  flush / redirect / fetch-tracking signals (slave side)
// ----------------------------------------------------------------------------
module qpu_ifu_flush_ctrl #(
  parameter int PC_SIZE = 32,
  parameter int OST_MAX = 4,
  parameter int OST_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  qpu_ifu_flush_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [OST_W-1:0] CNT_MAX = OST_W'(OST_MAX);
  localparam logic [OST_W-1:0] CNT_ONE = OST_W'(1);

  state_t             state;
  logic               redir_valid_q;
  logic [PC_SIZE-1:0] target;
  logic [OST_W-1:0]   ost_cnt;
  logic [OST_W-1:0]   discard_cnt;
  logic               ost_err_q;

  logic               flush_accept;
  logic               rsp_kill;
  logic               req_block;
  logic               err_event;
  logic [OST_W-1:0]   ost_nxt;
  logic [OST_W-1:0]   discard_dec;
  logic [OST_W-1:0]   flush_discard;

  assign flush_accept = (state == IDLE) && bus.brchmis_flush_req;

  // A response handshaking in the accept cycle is already wrong-path.
  assign rsp_kill  = bus.ifu_rsp_hsk && (flush_accept || (discard_cnt != '0));
  assign req_block = (state != IDLE) || bus.brchmis_flush_req || (ost_cnt == CNT_MAX);

  assign err_event = (bus.ifu_rsp_hsk && (ost_cnt == '0)) ||
                     (bus.ifu_req_hsk && req_block);

  // Discard count after this cycle's kill, saturating at zero.
  assign discard_dec = (rsp_kill && (discard_cnt != '0)) ? discard_cnt - CNT_ONE
                                                         : discard_cnt;

  // Responses in flight at accept time, minus the one killed right now.
  assign flush_discard = (bus.ifu_rsp_hsk && (ost_cnt != '0)) ? ost_cnt - CNT_ONE
                                                              : ost_cnt;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ost_nxt = ost_cnt;
    if (bus.ifu_req_hsk && !bus.ifu_rsp_hsk && (ost_cnt != CNT_MAX)) begin
      ost_nxt = ost_cnt + CNT_ONE;
    end else if (!bus.ifu_req_hsk && bus.ifu_rsp_hsk && (ost_cnt != '0)) begin
      ost_nxt = ost_cnt - CNT_ONE;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      redir_valid_q <= 1'b0;
      target        <= '0;
      ost_cnt       <= '0;
      discard_cnt   <= '0;
      ost_err_q     <= 1'b0;
    end else begin
      ost_cnt <= ost_nxt;
      if (err_event) begin
        ost_err_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (flush_accept) begin
            target        <= bus.brchmis_flush_add_op1 + bus.brchmis_flush_add_op2;
            discard_cnt   <= flush_discard;
            redir_valid_q <= 1'b1;
            state         <= REDIR;
          end else begin
            discard_cnt <= discard_dec;
          end
        end
        REDIR: begin
          discard_cnt <= discard_dec;
          if (bus.ifu_redirect_ready) begin
            redir_valid_q <= 1'b0;
            state         <= (discard_dec != '0) ? DRAIN : IDLE;
          end
        end
        DRAIN: begin
          discard_cnt <= discard_dec;
          if (discard_cnt == '0) begin
            state <= IDLE;
          end
        end
        default: begin
          redir_valid_q <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign bus.brchmis_flush_ack  = flush_accept;
  assign bus.ifu_redirect_valid = redir_valid_q;
  assign bus.ifu_redirect_pc    = target;
  assign bus.ifu_req_block      = req_block;
  assign bus.ifu_rsp_kill       = rsp_kill;
  assign bus.ost_err            = ost_err_q;

endmodule

// File: tb/tb_qpu_ifu_flush_ctrl.sv
// ----------------------------------------------------------------------------
// tb_qpu_ifu_flush_ctrl
//   Table of per-cycle {inputs, expected outputs} rows for qpu_ifu_flush_ctrl
//   (OST_MAX=4). Each row's expectation is queued when the row is driven and
//   popped and compared on the following falling edge.
// ----------------------------------------------------------------------------
module tb_qpu_ifu_flush_ctrl;
  localparam int PC_SIZE = 32;
  localparam int OST_MAX = 4;
  localparam int OST_W   = 4;

  typedef struct packed {
    logic        rst;
    logic        freq;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        rdy;
    logic        qh;
    logic        sh;
    logic        e_ack;
    logic        e_val;
    logic        c_pc;
    logic [31:0] e_pc;
    logic        e_kill;
    logic        e_blk;
    logic        e_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qpu_ifu_flush_ctrl_if #(.PC_SIZE(PC_SIZE)) bus ();

  qpu_ifu_flush_ctrl #(
    .PC_SIZE(PC_SIZE),
    .OST_MAX(OST_MAX),
    .OST_W  (OST_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int   n_assert = 0;
  int   n_fail   = 0;
  int   row      = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic r, input logic f, input logic [31:0] a,
                              input logic [31:0] b, input logic rd, input logic q,
                              input logic s, input logic ack, input logic val,
                              input logic cpc, input logic [31:0] pc, input logic kill,
                              input logic blk, input logic err);
    vec_t v;
    v = '{rst: r, freq: f, op1: a, op2: b, rdy: rd, qh: q, sh: s, e_ack: ack,
          e_val: val, c_pc: cpc, e_pc: pc, e_kill: kill, e_blk: blk, e_err: err};
    return v;
  endfunction

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL row %0d %s: got 0x%0h expected 0x%0h", row, what, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    rst                       = v.rst;
    bus.brchmis_flush_req     = v.freq;
    bus.brchmis_flush_add_op1 = v.op1;
    bus.brchmis_flush_add_op2 = v.op2;
    bus.ifu_redirect_ready    = v.rdy;
    bus.ifu_req_hsk           = v.qh;
    bus.ifu_rsp_hsk           = v.sh;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    check("flush_ack",      32'(bus.brchmis_flush_ack),  32'(e.e_ack));
    check("redirect_valid", 32'(bus.ifu_redirect_valid), 32'(e.e_val));
    if (e.c_pc) check("redirect_pc", bus.ifu_redirect_pc, e.e_pc);
    check("rsp_kill",       32'(bus.ifu_rsp_kill),       32'(e.e_kill));
    check("req_block",      32'(bus.ifu_req_block),      32'(e.e_blk));
    check("ost_err",        32'(bus.ost_err),            32'(e.e_err));
    @(posedge clk);
    #1;
    row++;
  endtask

  initial begin
    logic [31:0] a, b, sum;
    int          stall;

    rst                       = 1'b1;
    bus.brchmis_flush_req     = 1'b0;
    bus.brchmis_flush_add_op1 = '0;
    bus.brchmis_flush_add_op2 = '0;
    bus.ifu_redirect_ready    = 1'b0;
    bus.ifu_req_hsk           = 1'b0;
    bus.ifu_rsp_hsk           = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //               rst f  op1           op2     rdy qh sh   ack val cpc pc            kill blk err
    // Reset state
    tbl.push_back(mk(1, 0, 0,            0,      0, 0, 0,   0, 0, 1, 0,            0, 0, 0));
    // Idle flush, nothing outstanding
    tbl.push_back(mk(0, 1, 32'h1000,     32'h4,  1, 0, 0,   1, 0, 0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      1, 0, 0,   0, 1, 1, 32'h1004,     0, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 0,   0, 0, 0, 0,            0, 0, 0));
    // Wrap-around add
    tbl.push_back(mk(0, 1, 32'hFFFFFFF8, 32'h10, 0, 0, 0,   1, 0, 0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 0,   0, 1, 1, 32'h8,        0, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      1, 0, 0,   0, 1, 1, 32'h8,        0, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 0,   0, 0, 0, 0,            0, 0, 0));
    // Drain of three in-flight fetches, ready low four cycles
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 0,          0,      0, 1, 0,   0, 0, 0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h2000,     32'h40, 0, 0, 0,   1, 0, 0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 0,   0, 1, 1, 32'h2040,     0, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 1,   0, 1, 1, 32'h2040,     1, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 0,   0, 1, 1, 32'h2040,     0, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 0,   0, 1, 1, 32'h2040,     0, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      1, 0, 1,   0, 1, 1, 32'h2040,     1, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 1,   0, 0, 0, 0,            1, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 0,   0, 0, 0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 0,   0, 0, 0, 0,            0, 0, 0));
    // Flush with a simultaneous response at ost_cnt=2, then a flush held in DRAIN
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(0, 0, 0,          0,      0, 1, 0,   0, 0, 0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h3000,     32'h8,  0, 0, 1,   1, 0, 0, 0,            1, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      1, 0, 0,   0, 1, 1, 32'h3008,     0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h4000,     32'h4,  0, 0, 0,   0, 0, 0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h4000,     32'h4,  0, 0, 1,   0, 0, 0, 0,            1, 1, 0));
    tbl.push_back(mk(0, 1, 32'h4000,     32'h4,  0, 0, 0,   0, 0, 0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h4000,     32'h4,  0, 0, 0,   1, 0, 0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      1, 0, 0,   0, 1, 1, 32'h4004,     0, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 0,   0, 0, 0, 0,            0, 0, 0));
    // Backpressure at OST_MAX, illegal fifth request
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 0, 0,          0,      0, 1, 0,   0, 0, 0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 0,   0, 0, 0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 1, 0,   0, 0, 0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 0,   0, 0, 0, 0,            0, 1, 1));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 1,   0, 0, 0, 0,            0, 1, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 0,          0,      0, 0, 1,   0, 0, 0, 0,            0, 0, 1));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 0,   0, 0, 0, 0,            0, 0, 1));
    // Reset clears the sticky error; response with nothing outstanding sets it
    tbl.push_back(mk(1, 0, 0,            0,      0, 0, 0,   0, 0, 0, 0,            0, 0, 1));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 0,   0, 0, 0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 1,   0, 0, 0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 0,   0, 0, 0, 0,            0, 0, 1));
    tbl.push_back(mk(1, 0, 0,            0,      0, 0, 0,   0, 0, 0, 0,            0, 0, 1));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 0,   0, 0, 0, 0,            0, 0, 0));
    // Reset in REDIR with discard_cnt=2
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(0, 0, 0,          0,      0, 1, 0,   0, 0, 0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h5000,     32'h100,0, 0, 0,   1, 0, 0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 0,   0, 1, 1, 32'h5100,     0, 1, 0));
    tbl.push_back(mk(1, 0, 0,            0,      0, 0, 0,   0, 1, 1, 32'h5100,     0, 1, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 0,   0, 0, 1, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 1,   0, 0, 0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0,            0,      0, 0, 0,   0, 0, 0, 0,            0, 0, 1));

    foreach (tbl[i]) apply(tbl[i]);

    // Random operands with a random-length redirect stall (ost_err still set).
    a     = $urandom;
    b     = $urandom;
    sum   = a + b;
    stall = $urandom_range(1, 6);
    apply(mk(0, 1, a, b, 0, 0, 0,   1, 0, 0, 0,   0, 1, 1));
    for (int i = 0; i < stall; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, sum, 0, 1, 1));
    apply(mk(0, 0, 0, 0, 1, 0, 0,   0, 1, 1, sum, 0, 1, 1));
    apply(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
